// File: rtl/sync_filter_bank.sv
// Multi-channel input conditioner: N-flop synchroniser, stable-count glitch filter,
// edge pulses and sticky W1C event flags. `define SYNC_BANK_FILTER_EN enables the counter filter.

module sync_filter_lane #(
  parameter int   STAGES    = 2,
  parameter int   FILT_CNT  = 4,
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  input  logic clear,
  output logic sync_out,
  output logic filt_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic event_sticky
);

  logic [STAGES-1:0] chain;
  logic              change;
  logic              rise_next;
  logic              fall_next;

  // Only chain[0] ever sees the asynchronous level.
  always_ff @(posedge clk) begin
    if (reset) chain <= {STAGES{RESET_BIT}};
    else       chain <= {chain[STAGES-2:0], async_in};
  end

  assign sync_out = chain[STAGES-1];

`ifdef SYNC_BANK_FILTER_EN
  localparam int CW = $clog2(FILT_CNT + 1);

  logic [CW-1:0] cnt;

  // Counter tracks consecutive cycles of disagreement; any agreement restarts it.
  assign change = (sync_out != filt_out) && (cnt == CW'(FILT_CNT - 1));

  always_ff @(posedge clk) begin
    if (reset)                              cnt <= '0;
    else if ((sync_out == filt_out) || change) cnt <= '0;
    else                                    cnt <= cnt + 1'b1;
  end
`else
  assign change = (sync_out != filt_out);
`endif

  assign rise_next = change &  sync_out;
  assign fall_next = change & ~sync_out;

  // A new edge in the same cycle as clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_out     <= RESET_BIT;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      event_sticky <= 1'b0;
    end else begin
      if (change) filt_out <= sync_out;
      rise_pulse   <= rise_next;
      fall_pulse   <= fall_next;
      event_sticky <= (event_sticky & ~clear) | rise_next | fall_next;
    end
  end

endmodule

module sync_filter_bank #(
  parameter int               WIDTH     = 8,
  parameter int               STAGES    = 2,
  parameter int               FILT_CNT  = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  input  logic [WIDTH-1:0] clear,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] filt_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] event_sticky,
  output logic             any_event
);

  if (WIDTH < 1 || WIDTH > 32)       begin : g_bad_width $error("WIDTH out of range");    end
  if (STAGES < 2 || STAGES > 4)      begin : g_bad_stages $error("STAGES out of range");  end
  if (FILT_CNT < 1 || FILT_CNT > 255) begin : g_bad_cnt $error("FILT_CNT out of range"); end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    sync_filter_lane #(
      .STAGES    (STAGES),
      .FILT_CNT  (FILT_CNT),
      .RESET_BIT (RESET_VAL[i])
    ) u_lane (
      .clk          (clk),
      .reset        (reset),
      .async_in     (async_in[i]),
      .clear        (clear[i]),
      .sync_out     (sync_out[i]),
      .filt_out     (filt_out[i]),
      .rise_pulse   (rise_pulse[i]),
      .fall_pulse   (fall_pulse[i]),
      .event_sticky (event_sticky[i])
    );
  end

  assign any_event = |event_sticky;

endmodule

// File: tb/tb_sync_filter_bank.sv
// Randomised scoreboard bench for sync_filter_bank: a cycle-level reference model
// (delay line + disagreement streak per channel) predicts every output after each edge.

module tb_sync_filter_bank;

  localparam int         WIDTH    = 8;
  localparam int         STAGES   = 2;
  localparam int         FILT_CNT = 4;
  localparam logic [7:0] RV       = 8'hA5;
`ifdef SYNC_BANK_FILTER_EN
  localparam int         F        = FILT_CNT;
`else
  localparam int         F        = 1;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] async_in;
  logic [WIDTH-1:0] clear;
  logic [WIDTH-1:0] sync_out, filt_out, rise_pulse, fall_pulse, event_sticky;
  logic             any_event;

  sync_filter_bank #(
    .WIDTH(WIDTH), .STAGES(STAGES), .FILT_CNT(FILT_CNT), .RESET_VAL(RV)
  ) dut (
    .clk(clk), .reset(reset), .async_in(async_in), .sync_out(sync_out),
    .filt_out(filt_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .event_sticky(event_sticky), .clear(clear), .any_event(any_event)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sync;
    logic [7:0] filt;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] sticky;
    logic       any;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;

  // Reference state
  logic [7:0] m_dl[$];
  logic [7:0] m_filt, m_rise, m_fall, m_sticky;
  int         m_streak[WIDTH];
  logic [7:0] lvl;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict the state after the next posedge given the inputs held across it.
  task automatic model_edge(input logic r, input logic [7:0] a, input logic [7:0] c);
    logic [7:0] s;
    logic [7:0] nr;
    logic [7:0] nf;
    exp_t       e;
    if (r) begin
      m_dl.delete();
      repeat (STAGES) m_dl.push_back(RV);
      m_filt = RV; m_rise = '0; m_fall = '0; m_sticky = '0;
      for (int i = 0; i < WIDTH; i++) m_streak[i] = 0;
    end else begin
      s = m_dl[0];
      nr = '0; nf = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (s[i] == m_filt[i]) m_streak[i] = 0;
        else begin
          m_streak[i]++;
          if (m_streak[i] >= F) begin
            m_streak[i] = 0;
            m_filt[i] = s[i];
            if (s[i]) nr[i] = 1'b1; else nf[i] = 1'b1;
          end
        end
      end
      m_dl.push_back(a);
      void'(m_dl.pop_front());
      m_rise = nr; m_fall = nf;
      m_sticky = (m_sticky & ~c) | nr | nf;
    end
    e.sync = m_dl[0]; e.filt = m_filt; e.rise = m_rise; e.fall = m_fall;
    e.sticky = m_sticky; e.any = |m_sticky;
    q.push_back(e);
  endtask

  task automatic apply(input logic r, input logic [7:0] a, input logic [7:0] c);
    reset = r; async_in = a; clear = c;
    model_edge(r, a, c);
  endtask

  task automatic step(input logic r, input logic [7:0] a, input logic [7:0] c);
    @(posedge clk);
    #2;
    apply(r, a, c);
  endtask

  // Monitor: compare every cycle once a prediction is available.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("sync_out",     sync_out,     mon_e.sync);
        chk("filt_out",     filt_out,     mon_e.filt);
        chk("rise_pulse",   rise_pulse,   mon_e.rise);
        chk("fall_pulse",   fall_pulse,   mon_e.fall);
        chk("event_sticky", event_sticky, mon_e.sticky);
        chk("any_event",    {7'd0, any_event}, {7'd0, mon_e.any});
      end
    end
  end

  initial begin
    // Reset with inputs matching RESET_VAL, then hold: no pulses expected.
    apply(1'b1, RV, '0);
    repeat (3) step(1'b1, RV, '0);
    repeat (20) step(1'b0, RV, '0);

    // Clean fall then rise on channel 0.
    lvl = RV;
    lvl[0] = 1'b0;
    repeat (10) step(1'b0, lvl, '0);
    lvl[0] = 1'b1;
    repeat (10) step(1'b0, lvl, '0);

    // Two-cycle glitch on channel 3.
    lvl[3] = 1'b1;
    repeat (2) step(1'b0, lvl, '0);
    lvl[3] = 1'b0;
    repeat (10) step(1'b0, lvl, '0);
    step(1'b0, lvl, 8'hFF);
    repeat (3) step(1'b0, lvl, '0);

    // Channel 5 toggled, reset issued mid-count.
    lvl[5] = ~lvl[5];
    repeat (3) step(1'b0, lvl, '0);
    step(1'b1, lvl, '0);
    repeat (8) step(1'b0, lvl, '0);

    // Busy random traffic: frequent glitches, dense clears, rare resets.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < WIDTH; i++)
        if ($urandom_range(0, 5) == 0) lvl[i] = ~lvl[i];
      step(($urandom_range(0, 199) == 0), lvl, 8'($urandom & $urandom));
    end

    // Slow random traffic so most transitions pass the filter.
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < WIDTH; i++)
        if ($urandom_range(0, 15) == 0) lvl[i] = ~lvl[i];
      step(1'b0, lvl, 8'($urandom & $urandom & $urandom));
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
